// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO with
// valid/ready on both sides, synchronous flush and misalignment flag.
module inst_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_vaddr,
    input  logic [DATA_W-1:0]          in_inst,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_W-1:0]          out_vaddr,
    output logic [DATA_W-1:0]          out_inst,
    output logic                       out_addr_err,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] vaddr_mem [DEPTH];
    logic [DATA_W-1:0] inst_mem  [DEPTH];
    logic              err_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic push;
    logic pop;

    assign in_ready  = (cnt != FULL);
    assign out_valid = (cnt != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_vaddr    = vaddr_mem[rd_ptr];
    assign out_inst     = inst_mem[rd_ptr];
    assign out_addr_err = err_mem[rd_ptr];
    assign count        = cnt;

    // Storage is left uninitialised; only pointers and occupancy are reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            vaddr_mem[wr_ptr] <= in_vaddr;
            inst_mem[wr_ptr]  <= in_inst;
            err_mem[wr_ptr]   <= |in_vaddr[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: scoreboard queue of pushed entries,
// popped and compared as decode consumes them.
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_vaddr;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_vaddr;
    logic [31:0] out_inst;
    logic        out_addr_err;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] va;
        logic [31:0] ins;
        logic        err;
    } ent_t;

    ent_t sb[$];
    int checks = 0;
    int failures = 0;

    inst_queue #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vaddr(in_vaddr), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vaddr(out_vaddr), .out_inst(out_inst),
        .out_addr_err(out_addr_err), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard bookkeeping only: log an accepted push.
    task automatic record_push();
        ent_t e;
        if (in_valid && in_ready && !flush) begin
            e.va  = in_vaddr;
            e.ins = in_inst;
            e.err = |in_vaddr[1:0];
            sb.push_back(e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_vaddr = '0; in_inst = '0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL reset_async rdy=%b vld=%b cnt=%0d exp 1 0 0",
                     in_ready, out_valid, count);
        end
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
                failures++;
                $display("FAIL reset_idle rdy=%b vld=%b cnt=%0d exp 1 0 0",
                         in_ready, out_valid, count);
            end
        end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_vaddr = 32'hbfc00000 + 32'(4 * i);
            in_inst  = 32'h11111111 * 32'(i + 1);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL fill_ready got=%b exp=1", in_ready);
            end
            record_push();
            tick();
            checks++;
            if (count !== 3'(i + 1)) begin
                failures++;
                $display("FAIL fill_count got=%0d exp=%0d", count, i + 1);
            end
        end
        in_vaddr = 32'hbfc00010;
        in_inst  = 32'h55555555;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_ready got=%b exp=0", in_ready);
        end
        record_push();
        tick();
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("FAIL full_hold got=%0d exp=4", count);
        end
    endtask

    task automatic test_drain();
        ent_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                failures++;
                $display("FAIL drain_valid got=%b sb=%0d", out_valid, sb.size());
            end else begin
                e = sb.pop_front();
                if (out_vaddr !== e.va || out_inst !== e.ins || out_addr_err !== e.err) begin
                    failures++;
                    $display("FAIL drain_data got=%h/%h/%b exp=%h/%h/%b",
                             out_vaddr, out_inst, out_addr_err, e.va, e.ins, e.err);
                end
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || sb.size() != 0) begin
            failures++;
            $display("FAIL drain_empty vld=%b cnt=%0d exp 0 0", out_valid, count);
        end
    endtask

    task automatic test_stream();
        ent_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            if (i == 0) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL stream_start got=%b exp=0", out_valid);
                end
            end else begin
                checks++;
                if (out_valid !== 1'b1 || sb.size() == 0) begin
                    failures++;
                    $display("FAIL stream_valid i=%0d got=%b", i, out_valid);
                end else begin
                    e = sb.pop_front();
                    if (out_vaddr !== e.va || out_inst !== e.ins) begin
                        failures++;
                        $display("FAIL stream_data i=%0d got=%h/%h exp=%h/%h",
                                 i, out_vaddr, out_inst, e.va, e.ins);
                    end
                end
                checks++;
                if (count !== 3'd1) begin
                    failures++;
                    $display("FAIL stream_count i=%0d got=%0d exp=1", i, count);
                end
            end
            in_valid = (i < 20);
            in_vaddr = 32'h80001000 + 32'(4 * i);
            in_inst  = 32'hc0de0000 + 32'(i);
            record_push();
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL stream_end vld=%b sb=%0d exp 0 0", out_valid, sb.size());
        end
    endtask

    task automatic test_flush();
        ent_t e;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_vaddr = 32'hbfc00200 + 32'(4 * i);
            in_inst  = 32'ha0000000 + 32'(i);
            record_push();
            tick();
        end
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("FAIL flush_pre got=%0d exp=3", count);
        end
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_vaddr = 32'hbfc0020c; in_inst = 32'hdeadbeef;
        tick();
        sb.delete();
        flush = 1'b0; out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear cnt=%0d vld=%b rdy=%b exp 0 0 1",
                     count, out_valid, in_ready);
        end
        in_valid = 1'b1; in_vaddr = 32'hbfc00380; in_inst = 32'h12345678;
        record_push();
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            failures++;
            $display("FAIL flush_next_valid got=%b exp=1", out_valid);
        end else begin
            e = sb.pop_front();
            if (out_vaddr !== e.va || out_inst !== e.ins || out_vaddr !== 32'hbfc00380) begin
                failures++;
                $display("FAIL flush_next_data got=%h/%h exp=%h/%h",
                         out_vaddr, out_inst, e.va, e.ins);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_misaligned();
        ent_t e;
        logic exp_err [2];
        exp_err[0] = 1'b1;
        exp_err[1] = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1; in_vaddr = 32'hbfc00002; in_inst = 32'h0000000d;
        record_push();
        tick();
        in_vaddr = 32'hbfc00004; in_inst = 32'h0000000e;
        record_push();
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1 || sb.size() == 0) begin
                failures++;
                $display("FAIL misalign_valid i=%0d got=%b", i, out_valid);
            end else begin
                e = sb.pop_front();
                if (out_addr_err !== exp_err[i] || out_addr_err !== e.err ||
                    out_vaddr !== e.va) begin
                    failures++;
                    $display("FAIL misalign_err i=%0d got=%b/%h exp=%b/%h",
                             i, out_addr_err, out_vaddr, exp_err[i], e.va);
                end
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_vaddr = 32'hbfc00500 + 32'(4 * i);
            in_inst  = 32'hb0000000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (count !== 3'd2 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre cnt=%0d vld=%b exp 2 1", count, out_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL areset_drop vld=%b cnt=%0d rdy=%b exp 0 0 1",
                     out_valid, count, in_ready);
        end
        tick();
        rst = 1'b0;
        sb.delete();
        tick();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL areset_after vld=%b cnt=%0d exp 0 0", out_valid, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_flush();
        test_misaligned();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
